// File: rtl/des.sv
// rtl/des.sv - DES initial/final permutation stage, one registered 64-bit block per cycle.
// DES bit position p maps to vector index 64-p; output position k takes input position T[k].
module des #(
  parameter bit INVERSE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        inv_i,
  input  logic [63:0] block_i,
  output logic [63:0] block_o,
  output logic        valid_o
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  logic [63:0] ip_w;
  logic [63:0] fp_w;
  logic        sel_fp_w;
  logic [63:0] block_d, block_q;
  logic        valid_d, valid_q;

  for (genvar k = 1; k <= 64; k++) begin : g_ip
    assign ip_w[64-k] = block_i[64-IP_T[k-1]];
  end

  // Without INVERSE_EN the FP network is not built and inv_i has no effect.
  if (INVERSE_EN) begin : g_fp
    for (genvar k = 1; k <= 64; k++) begin : g_bit
      assign fp_w[64-k] = block_i[64-FP_T[k-1]];
    end
    assign sel_fp_w = inv_i;
  end else begin : g_no_fp
    assign fp_w     = ip_w;
    assign sel_fp_w = 1'b0;
  end

  always_comb begin
    block_d = block_q;
    valid_d = 1'b0;
    if (valid_i) begin
      block_d = sel_fp_w ? fp_w : ip_w;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      block_q <= 64'h0;
      valid_q <= 1'b0;
    end else begin
      block_q <= block_d;
      valid_q <= valid_d;
    end
  end

  assign block_o = block_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_des.sv
// tb/tb_des.sv - scoreboard bench for the DES permutation stage.
// Every driven cycle pushes the expected (valid_o, block_o); the monitor pops one per edge.
module tb_des;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        inv_i = 1'b0;
  logic [63:0] block_i = 64'h0;
  logic [63:0] block_o;
  logic        valid_o;

  des #(.INVERSE_EN(1'b1)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .inv_i   (inv_i),
    .block_i (block_i),
    .block_o (block_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        valid;
    logic [63:0] block;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] held = 64'h0;

  int ip_t [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ip_m(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 1; k <= 64; k++) y[64-k] = x[64-ip_t[k-1]];
    return y;
  endfunction

  // FP is modelled as the inverse scatter of IP rather than from its own table.
  function automatic logic [63:0] fp_m(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 1; k <= 64; k++) y[64-ip_t[k-1]] = x[64-k];
    return y;
  endfunction

  task automatic cyc(input logic rst, input logic v, input logic inv, input logic [63:0] blk,
                     input bit use_exp, input logic [63:0] exp_blk);
    exp_t e;
    @(negedge clk_i);
    rst_i   = rst;
    valid_i = v;
    inv_i   = inv;
    block_i = blk;
    if (rst) begin
      held = 64'h0;
      e.valid = 1'b0;
    end else if (v) begin
      held = use_exp ? exp_blk : (inv ? fp_m(blk) : ip_m(blk));
      e.valid = 1'b1;
    end else begin
      e.valid = 1'b0;
    end
    e.block = held;
    exp_q.push_back(e);
  endtask

  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid_o", {63'h0, valid_o}, {63'h0, e.valid});
      check("block_o", block_o, e.block);
    end
  end

  initial begin
    logic [63:0] x;
    // reset, then idle
    cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    cyc(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1111, 1'b0, 64'h0);
    // known vectors, back-to-back, then idle hold
    cyc(1'b0, 1'b1, 1'b0, 64'h123456ABCD132536, 1'b1, 64'h14A7D67818CA18AD);
    cyc(1'b0, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b1, 64'hCC00CCFFF0AAF0AA);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0);
    cyc(1'b0, 1'b0, 1'b1, 64'h5555_5555_5555_5555, 1'b1, 64'h0);
    cyc(1'b0, 1'b1, 1'b1, 64'h14A7D67818CA18AD, 1'b1, 64'h123456ABCD132536);
    // single-bit inputs through IP and FP
    for (int p = 1; p <= 64; p++) begin
      x = 64'h0;
      x[64-p] = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, x, 1'b0, 64'h0);
      cyc(1'b0, 1'b1, 1'b1, x, 1'b0, 64'h0);
    end
    // FP(IP(x)) == x with random x, interleaved with random IP and idle cycles
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom(), $urandom()};
      cyc(1'b0, 1'b1, 1'b1, ip_m(x), 1'b1, x);
      if (i % 7 == 0) cyc(1'b0, 1'b1, 1'b0, x, 1'b0, 64'h0);
      if (i % 11 == 0) cyc(1'b0, 1'b0, 1'b0, x, 1'b0, 64'h0);
    end
    // reset wins over valid mid-stream
    cyc(1'b0, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b1, 64'hCC00CCFFF0AAF0AA);
    cyc(1'b1, 1'b1, 1'b0, 64'h123456ABCD132536, 1'b0, 64'h0);
    cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
